// File: rtl/pipe_pkg.sv
// Shared types for the fetch->decode pipeline stage: FSM state encoding and payload layout.
package pipe_pkg;

   typedef enum logic [1:0] {
      EMPTY = 2'd0,
      FULL  = 2'd1,
      SKID  = 2'd2
   } pipe_state_t;

   localparam logic [31:0] NOP_INSTR_DEFAULT = 32'h00000013;
   localparam int          PIPE_WORD_W       = 32;
   localparam int          PIPE_SB_W         = 1;

   // Reference layout at default widths; the stage re-declares it locally for its parameters.
   typedef struct packed {
      logic [PIPE_WORD_W-1:0] instr;
      logic [PIPE_WORD_W-1:0] pc;
      logic [PIPE_WORD_W-1:0] pcplus4;
      logic [PIPE_SB_W-1:0]   sb;
   } fd_payload_t;

endpackage

// File: rtl/pipe_skid_ctrl.sv
// Occupancy FSM for the F->D stage; emits load/clear strobes, the parent owns the datapath.
//
//   state | meaning
//   EMPTY | no entry held, decode sees NOP, fetch may transfer
//   FULL  | main entry valid, skid free, fetch may transfer
//   SKID  | main and skid both valid, fetch is stalled
module pipe_skid_ctrl
   import pipe_pkg::*;
(
   input  logic       clk,
   input  logic       reset,
   input  logic       validF,
   input  logic       readyD,
   input  logic       flushD,
   output logic [1:0] state,
   output logic       load_main_from_F,
   output logic       load_main_from_skid,
   output logic       load_skid,
   output logic       clear_main
);

   pipe_state_t state_q;
   pipe_state_t state_d;
   logic        take_f;
   logic        take_d;

   assign take_f = validF && (state_q != SKID);
   assign take_d = readyD && (state_q != EMPTY);
   assign state  = state_q;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) state_q <= EMPTY;
      else       state_q <= state_d;
   end

   always_comb begin
      state_d             = state_q;
      load_main_from_F    = 1'b0;
      load_main_from_skid = 1'b0;
      load_skid           = 1'b0;
      clear_main          = 1'b0;
      // A flush wins over everything; an incoming fetch in the same cycle is dropped.
      if (flushD) begin
         state_d    = EMPTY;
         clear_main = 1'b1;
      end else begin
         unique case (state_q)
            EMPTY: begin
               if (take_f) begin
                  load_main_from_F = 1'b1;
                  state_d          = FULL;
               end
            end
            FULL: begin
               if (take_d && take_f) begin
                  load_main_from_F = 1'b1;
               end else if (take_d) begin
                  clear_main = 1'b1;
                  state_d    = EMPTY;
               end else if (take_f) begin
                  load_skid = 1'b1;
                  state_d   = SKID;
               end
            end
            SKID: begin
               if (take_d) begin
                  load_main_from_skid = 1'b1;
                  state_d             = FULL;
               end
            end
            default: begin
               clear_main = 1'b1;
               state_d    = EMPTY;
            end
         endcase
      end
   end

endmodule

// File: rtl/fd_pipe_stage.sv
// Fetch->decode stage with valid/ready handshake, two-entry skid buffer and flush.
// readyF and validD decode only the state flops, so no combinational ready path exists.
module fd_pipe_stage
   import pipe_pkg::*;
#(
   parameter int                    word_width = 32,
   parameter int                    SB_W       = 1,
   parameter logic [word_width-1:0] NOP_INSTR  = NOP_INSTR_DEFAULT
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic                  validF,
   output logic                  readyF,
   input  logic [word_width-1:0] instrF,
   input  logic [word_width-1:0] PCF,
   input  logic [word_width-1:0] PCPlus4F,
   input  logic [SB_W-1:0]       sbF,
   input  logic                  flushD,
   output logic                  validD,
   input  logic                  readyD,
   output logic [word_width-1:0] instrD,
   output logic [word_width-1:0] PCD,
   output logic [word_width-1:0] PCPlus4D,
   output logic [SB_W-1:0]       sbD
);

   if (SB_W < 1) begin : g_bad_sb_w
      $error("fd_pipe_stage: SB_W must be at least 1");
   end

   typedef struct packed {
      logic [word_width-1:0] instr;
      logic [word_width-1:0] pc;
      logic [word_width-1:0] pcplus4;
      logic [SB_W-1:0]       sb;
   } payload_t;

   localparam payload_t NOP_P = '{instr: NOP_INSTR, pc: '0, pcplus4: '0, sb: '0};

   logic [1:0] state;
   logic       load_main_from_F;
   logic       load_main_from_skid;
   logic       load_skid;
   logic       clear_main;
   payload_t   main_q;
   payload_t   skid_q;
   payload_t   in_p;

   pipe_skid_ctrl u_ctrl (
      .clk                 (clk),
      .reset               (reset),
      .validF              (validF),
      .readyD              (readyD),
      .flushD              (flushD),
      .state               (state),
      .load_main_from_F    (load_main_from_F),
      .load_main_from_skid (load_main_from_skid),
      .load_skid           (load_skid),
      .clear_main          (clear_main)
   );

   assign in_p = '{instr: instrF, pc: PCF, pcplus4: PCPlus4F, sb: sbF};

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         main_q <= NOP_P;
         skid_q <= '0;
      end else begin
         // Main is forced to NOP whenever the stage empties so decode never sees stale data.
         if (clear_main)               main_q <= NOP_P;
         else if (load_main_from_F)    main_q <= in_p;
         else if (load_main_from_skid) main_q <= skid_q;

         if (flushD)         skid_q <= '0;
         else if (load_skid) skid_q <= in_p;
      end
   end

   assign readyF   = (pipe_state_t'(state) != SKID);
   assign validD   = (pipe_state_t'(state) != EMPTY);
   assign instrD   = main_q.instr;
   assign PCD      = main_q.pc;
   assign PCPlus4D = main_q.pcplus4;
   assign sbD      = main_q.sb;

endmodule
